// File: rtl/lite_mem_arbiter_if.sv
// Bus bundle between the Xillybus Lite host port, the fabric requester and
// the register-memory arbiter.
//   user_*  : host (ARM) side, never stalled, registered read data + IRQ
//   fab_*   : fabric req/gnt handshake, registered read return, starvation flag
// Modports:
//   master : the side that issues accesses (host + fabric requester)
//   slave  : the arbiter that owns the memory
interface lite_mem_arbiter_if #(
  parameter int ADDR_W = 5
);
  // host port
  logic              user_wren;
  logic [3:0]        user_wstrb;
  logic              user_rden;
  logic [31:0]       user_addr;
  logic [31:0]       user_wr_data;
  logic [31:0]       user_rd_data;
  logic              user_irq;
  // fabric port
  logic              fab_req;
  logic              fab_we;
  logic [ADDR_W-1:0] fab_addr;
  logic [3:0]        fab_be;
  logic [31:0]       fab_wdata;
  logic              fab_gnt;
  logic              fab_rvalid;
  logic [31:0]       fab_rdata;
  logic              fab_starved;

  modport master (
    output user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
    input  user_rd_data, user_irq,
    output fab_req, fab_we, fab_addr, fab_be, fab_wdata,
    input  fab_gnt, fab_rvalid, fab_rdata, fab_starved
  );

  modport slave (
    input  user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
    output user_rd_data, user_irq,
    input  fab_req, fab_we, fab_addr, fab_be, fab_wdata,
    output fab_gnt, fab_rvalid, fab_rdata, fab_starved
  );
endinterface

// File: rtl/lite_mem_arbiter.sv
// lite_mem_arbiter
// Owns a 2**ADDR_W x 32-bit byte-strobed register memory behind the
// Xillybus Lite host port and shares it with one fabric requester.
// The host always wins and is never stalled; the fabric is granted only in
// cycles where the host is idle. A fabric write to the doorbell word raises
// user_irq; a host write to that word clears it.
// Ports:
//   user_clk    : single clock, rising edge
//   user_rst_n  : asynchronous active-low reset
//   bus         : lite_mem_arbiter_if.slave (host user_* and fabric fab_*)
module lite_mem_arbiter #(
  parameter int ADDR_W        = 5,
  parameter int DOORBELL_ADDR = 31,
  parameter int STARVE_LIMIT  = 16,
  parameter int CNT_W         = 8
) (
  input logic               user_clk,
  input logic               user_rst_n,
  lite_mem_arbiter_if.slave bus
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DB_IDX = ADDR_W'(DOORBELL_ADDR);
  localparam logic [CNT_W-1:0]  LIMIT  = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, RDRET} state_t;

  // fabric request fields, only meaningful in the grant cycle
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } fab_req_t;

  state_t            state_q, state_d;
  fab_req_t          freq;
  logic              host_busy;
  logic              gnt;
  logic              fab_wr, fab_rd;
  logic [ADDR_W-1:0] host_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [31:0]       mem [DEPTH];
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              irq_q, rvalid_q, starved_q;
  logic [31:0]       user_rd_q, fab_rd_q;
  logic              unused_addr;

  assign freq      = '{we: bus.fab_we, addr: bus.fab_addr, be: bus.fab_be, wdata: bus.fab_wdata};
  assign host_busy = bus.user_wren | bus.user_rden;
  // upper byte-address bits are dropped, so the host window aliases
  assign host_idx  = bus.user_addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.user_addr[31:ADDR_W+2], bus.user_addr[1:0]};

  assign fab_wr = gnt &  freq.we;
  assign fab_rd = gnt & ~freq.we;

  // FSM: IDLE grants when the host is quiet; RDRET is the read-return bubble
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt = bus.fab_req & ~host_busy;
        if (gnt & ~freq.we) state_d = RDRET;
      end
      RDRET:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // single write port: host and fabric never write in the same cycle
  always_comb begin
    wr_idx  = host_idx;
    wr_be   = 4'b0000;
    wr_data = bus.user_wr_data;
    if (bus.user_wren) begin
      wr_be = bus.user_wstrb;
    end else if (fab_wr) begin
      wr_idx  = freq.addr;
      wr_be   = freq.be;
      wr_data = freq.wdata;
    end
  end

  // memory has no reset
  always_ff @(posedge user_clk) begin
    for (int b = 0; b < 4; b++)
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end

  // saturating count of ungranted request cycles
  always_comb begin
    wait_d = '0;
    if (bus.fab_req & ~gnt) wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q   <= IDLE;
      user_rd_q <= '0;
      fab_rd_q  <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
      wait_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // reads see pre-edge contents, so same-cycle wren+rden returns old data
      if (bus.user_rden) user_rd_q <= mem[host_idx];
      if (fab_rd)        fab_rd_q  <= mem[freq.addr];
      rvalid_q <= fab_rd;
      // set and clear are mutually exclusive through arbitration
      if (fab_wr && freq.addr == DB_IDX && |freq.be) irq_q <= 1'b1;
      else if (bus.user_wren && host_idx == DB_IDX)  irq_q <= 1'b0;
      wait_q    <= wait_d;
      // compare the next count so the flag tracks the counter register exactly
      starved_q <= (wait_d >= LIMIT);
    end
  end

  assign bus.fab_gnt      = gnt;
  assign bus.fab_rvalid   = rvalid_q;
  assign bus.fab_rdata    = fab_rd_q;
  assign bus.fab_starved  = starved_q;
  assign bus.user_rd_data = user_rd_q;
  assign bus.user_irq     = irq_q;

endmodule
